conv_frame_encoder: RTL and testbench

Transmit-side front end for the Viterbi link. It is a rate-1/2, K=3 convolutional encoder that groups the serial input into frames of FRAME_LEN bits. After each frame it appends K-1=2 zero tail bits, so the trellis returns to state 00 and the downstream decoder sees a terminated trellis. Input uses a valid/ready handshake. Output is a registered 2-bit symbol stream with valid and frame markers, and it feeds the channel/error-injection stage.

---
 rtl/conv_frame_encoder.sv | 140 ++++++++++++++
 tb/tb_conv_frame_encoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_encoder.sv
// Rate-1/2, K=3 convolutional encoder (G1=111, G0=101) with framing.
// Serial input bits are grouped into frames of FRAME_LEN bits. Each frame is
// terminated with two zero tail bits so the trellis returns to state 00.
// All outputs except ready_o are registered; ready_o is decoded from state.
module conv_frame_encoder #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             encoder_i,
  input  logic             enable_encoder_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic [1:0]       encoder_o,
  output logic             valid_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic [CNT_W-1:0] bit_ct_o,
  output logic [CNT_W-1:0] word_ct_o
);

  typedef enum logic [1:0] {StIdle, StData, StTail0, StTail1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       shift_q, shift_d;  // {s1, s0}: s1 is the most recent bit
  logic [1:0]       sym_q, sym_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic [CNT_W-1:0] bit_ct_q, bit_ct_d;
  logic [CNT_W-1:0] word_ct_q, word_ct_d;

  logic accept;
  logic last_bit;
  logic enc_en;
  logic enc_bit;

  // Input is accepted only in the data-collecting states.
  assign ready_o = (state_q == StIdle) || (state_q == StData);
  assign accept  = enable_encoder_i & ready_o;

  // True when the bit about to be accepted in DATA completes the frame.
  assign last_bit = (32'(bit_ct_q) + 32'd1) >= FRAME_LEN;

  // Next-state, counter and symbol computation.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    sym_d     = sym_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    end_d     = 1'b0;
    bit_ct_d  = bit_ct_q;
    word_ct_d = word_ct_q;
    enc_en    = 1'b0;
    enc_bit   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // flush_i has no effect here: there is no frame to terminate yet.
        if (accept) begin
          enc_en   = 1'b1;
          enc_bit  = encoder_i;
          start_d  = 1'b1;
          bit_ct_d = CNT_W'(1);
          state_d  = (FRAME_LEN == 1) ? StTail0 : StData;
        end
      end
      StData: begin
        if (accept) begin
          enc_en   = 1'b1;
          enc_bit  = encoder_i;
          bit_ct_d = bit_ct_q + 1'b1;
          if (last_bit || flush_i) begin
            state_d = StTail0;
          end
        end else if (flush_i) begin
          state_d = StTail0;
        end
      end
      StTail0: begin
        enc_en  = 1'b1;
        state_d = StTail1;
      end
      StTail1: begin
        enc_en    = 1'b1;
        end_d     = 1'b1;
        bit_ct_d  = '0;
        word_ct_d = word_ct_q + 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (enc_en) begin
      sym_d   = {enc_bit ^ shift_q[1] ^ shift_q[0], enc_bit ^ shift_q[0]};
      shift_d = {enc_bit, shift_q[1]};
      valid_d = 1'b1;
    end

    // Two zero tail bits already clear the register; force it for robustness.
    if (state_q == StTail1) begin
      shift_d = '0;
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      sym_q     <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      bit_ct_q  <= '0;
      word_ct_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      sym_q     <= sym_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      end_q     <= end_d;
      bit_ct_q  <= bit_ct_d;
      word_ct_q <= word_ct_d;
    end
  end

  assign encoder_o     = sym_q;
  assign valid_o       = valid_q;
  assign frame_start_o = start_q;
  assign frame_end_o   = end_q;
  assign bit_ct_o      = bit_ct_q;
  assign word_ct_o     = word_ct_q;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Bench for conv_frame_encoder: three instances (FRAME_LEN 4, 256, and 1 with
// a 2-bit counter) checked against a convolution model of whole frames.
module tb_conv_frame_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: FRAME_LEN=4
  logic d_a = 0, en_a = 0, fl_a = 0, rdy_a, vld_a, st_a, end_a;
  logic [1:0] sym_a;
  logic [15:0] bc_a, wc_a;
  // Instance B: FRAME_LEN=256
  logic d_b = 0, en_b = 0, fl_b = 0, rdy_b, vld_b, st_b, end_b;
  logic [1:0] sym_b;
  logic [15:0] bc_b, wc_b;
  // Instance C: FRAME_LEN=1, CNT_W=2
  logic d_c = 0, en_c = 0, fl_c = 0, rdy_c, vld_c, st_c, end_c;
  logic [1:0] sym_c;
  logic [1:0] bc_c, wc_c;

  conv_frame_encoder #(.FRAME_LEN(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .encoder_i(d_a), .enable_encoder_i(en_a), .flush_i(fl_a),
    .ready_o(rdy_a), .encoder_o(sym_a), .valid_o(vld_a), .frame_start_o(st_a),
    .frame_end_o(end_a), .bit_ct_o(bc_a), .word_ct_o(wc_a));

  conv_frame_encoder #(.FRAME_LEN(256), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .encoder_i(d_b), .enable_encoder_i(en_b), .flush_i(fl_b),
    .ready_o(rdy_b), .encoder_o(sym_b), .valid_o(vld_b), .frame_start_o(st_b),
    .frame_end_o(end_b), .bit_ct_o(bc_b), .word_ct_o(wc_b));

  conv_frame_encoder #(.FRAME_LEN(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .encoder_i(d_c), .enable_encoder_i(en_c), .flush_i(fl_c),
    .ready_o(rdy_c), .encoder_o(sym_c), .valid_o(vld_c), .frame_start_o(st_c),
    .frame_end_o(end_c), .bit_ct_o(bc_c), .word_ct_o(wc_c));

  // Expected symbol stream, each entry {frame_start, frame_end, g1, g0}.
  logic [3:0] exp_q[$];

  // Convolve a frame (plus two zero tail bits) with 111 and 101.
  function automatic void add_frame(input bit bits[$]);
    int n;
    n = bits.size();
    for (int i = 0; i < n + 2; i++) begin
      bit b, p1, p2;
      b  = (i < n) ? bits[i] : 1'b0;
      p1 = (i >= 1 && i - 1 < n) ? bits[i-1] : 1'b0;
      p2 = (i >= 2 && i - 2 < n) ? bits[i-2] : 1'b0;
      exp_q.push_back({(i == 0), (i == n + 1), b ^ p1 ^ p2, b ^ p2});
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_checks++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a: got %b want 1", rdy_a); end
    n_checks++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b want 0", vld_a); end
    n_checks++; if (sym_a !== 2'b00) begin n_fail++; $display("FAIL reset_sym_a: got %b want 00", sym_a); end
    n_checks++; if ({st_a, end_a} !== 2'b00) begin n_fail++; $display("FAIL reset_markers_a: got %b want 00", {st_a, end_a}); end
    n_checks++; if (bc_a !== 16'd0) begin n_fail++; $display("FAIL reset_bit_ct_a: got %0d want 0", bc_a); end
    n_checks++; if (wc_a !== 16'd0) begin n_fail++; $display("FAIL reset_word_ct_a: got %0d want 0", wc_a); end
    n_checks++; if ({rdy_b, vld_b, wc_b} !== {2'b10, 16'd0}) begin n_fail++; $display("FAIL reset_b: got %b want 10_0", {rdy_b, vld_b, wc_b}); end
    n_checks++; if ({rdy_c, vld_c, wc_c} !== 4'b1000) begin n_fail++; $display("FAIL reset_c: got %b want 1000", {rdy_c, vld_c, wc_c}); end
    rst = 1'b1;
    tick();
    n_checks++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL idle_valid_a: got %b want 0", vld_a); end
  endtask

  // Bits 1,0,1,1 back-to-back -> 11,10,00,01 then tail 01,11.
  task automatic test_basic_frame();
    bit bits[4];
    logic [1:0] want[6];
    bits = '{1, 0, 1, 1};
    want = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    en_a = 1'b1; d_a = bits[0];
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++; if (vld_a !== 1'b1) begin n_fail++; $display("FAIL basic_valid k=%0d: got %b want 1", k, vld_a); end
      n_checks++; if (sym_a !== want[k]) begin n_fail++; $display("FAIL basic_sym k=%0d: got %b want %b", k, sym_a, want[k]); end
      n_checks++; if ({st_a, end_a} !== {(k == 0), (k == 5)}) begin n_fail++; $display("FAIL basic_markers k=%0d: got %b want %b", k, {st_a, end_a}, {(k == 0), (k == 5)}); end
      n_checks++; if (rdy_a !== !(k == 3 || k == 4)) begin n_fail++; $display("FAIL basic_ready k=%0d: got %b want %b", k, rdy_a, !(k == 3 || k == 4)); end
      if (k < 3) d_a = bits[k+1];
      else en_a = 1'b0;
    end
    tick();
    n_checks++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %b want 0", vld_a); end
    n_checks++; if (sym_a !== 2'b11) begin n_fail++; $display("FAIL basic_hold_sym: got %b want 11", sym_a); end
    n_checks++; if (wc_a !== 16'd1) begin n_fail++; $display("FAIL basic_word_ct: got %0d want 1", wc_a); end
    n_checks++; if (bc_a !== 16'd0) begin n_fail++; $display("FAIL basic_bit_ct: got %0d want 0", bc_a); end
  endtask

  // Same frame with a 3-cycle enable gap after the 2nd bit; tail ignores en.
  task automatic test_gap();
    bit en_s[7];
    bit d_s[7];
    bit fr[$];
    logic [3:0] e;
    logic [1:0] held;
    bit exp_v;
    en_s = '{1, 1, 0, 0, 0, 1, 1};
    d_s  = '{1, 0, 0, 0, 0, 1, 1};
    fr = '{1, 0, 1, 1};
    exp_q.delete();
    add_frame(fr);
    held = 2'b11;
    for (int k = 0; k < 9; k++) begin
      if (k < 7) begin
        en_a = en_s[k];
        d_a  = en_s[k] ? d_s[k] : 1'($urandom);
      end else begin
        en_a = 1'b1;
        d_a  = 1'($urandom);
      end
      tick();
      exp_v = (k < 7) ? en_s[k] : 1'b1;
      n_checks++; if (vld_a !== exp_v) begin n_fail++; $display("FAIL gap_valid k=%0d: got %b want %b", k, vld_a, exp_v); end
      if (exp_v) begin
        e = exp_q.pop_front();
        held = e[1:0];
        n_checks++; if ({st_a, end_a, sym_a} !== e) begin n_fail++; $display("FAIL gap_sym k=%0d: got %b want %b", k, {st_a, end_a, sym_a}, e); end
      end else begin
        n_checks++; if (sym_a !== held) begin n_fail++; $display("FAIL gap_hold k=%0d: got %b want %b", k, sym_a, held); end
      end
      if (k >= 1 && k <= 4) begin
        n_checks++; if (bc_a !== 16'd2) begin n_fail++; $display("FAIL gap_bit_ct k=%0d: got %0d want 2", k, bc_a); end
      end
    end
    en_a = 1'b0;
    tick();
    n_checks++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL gap_no_restart: got %b want 0", vld_a); end
    n_checks++; if (wc_a !== 16'd2) begin n_fail++; $display("FAIL gap_word_ct: got %0d want 2", wc_a); end
  endtask

  // Flush with the 2nd bit (flush in IDLE ignored), then flush with no bit.
  task automatic test_flush();
    bit en_s[8], d_s[8], fl_s[8], v_s[8], r_s[8];
    bit fr[$];
    logic [3:0] e;
    en_s = '{1, 1, 0, 0, 1, 0, 0, 0};
    d_s  = '{1, 1, 0, 0, 1, 0, 0, 0};
    fl_s = '{1, 1, 0, 0, 0, 1, 0, 0};
    v_s  = '{1, 1, 1, 1, 1, 0, 1, 1};
    r_s  = '{1, 0, 0, 1, 1, 0, 0, 1};
    exp_q.delete();
    fr = '{1, 1};
    add_frame(fr);
    fr = '{1};
    add_frame(fr);
    for (int k = 0; k < 8; k++) begin
      en_a = en_s[k]; d_a = d_s[k]; fl_a = fl_s[k];
      tick();
      n_checks++; if (vld_a !== v_s[k]) begin n_fail++; $display("FAIL flush_valid k=%0d: got %b want %b", k, vld_a, v_s[k]); end
      n_checks++; if (rdy_a !== r_s[k]) begin n_fail++; $display("FAIL flush_ready k=%0d: got %b want %b", k, rdy_a, r_s[k]); end
      if (v_s[k]) begin
        e = exp_q.pop_front();
        n_checks++; if ({st_a, end_a, sym_a} !== e) begin n_fail++; $display("FAIL flush_sym k=%0d: got %b want %b", k, {st_a, end_a, sym_a}, e); end
      end
      if (k == 3) begin
        n_checks++; if (bc_a !== 16'd0) begin n_fail++; $display("FAIL flush_bit_ct: got %0d want 0", bc_a); end
        n_checks++; if (wc_a !== 16'd3) begin n_fail++; $display("FAIL flush_word_ct: got %0d want 3", wc_a); end
      end
    end
    en_a = 1'b0; fl_a = 1'b0;
    n_checks++; if (wc_a !== 16'd4) begin n_fail++; $display("FAIL flush_word_ct2: got %0d want 4", wc_a); end
  endtask

  // Reset during the 2nd tail cycle: no frame_end, next frame from state 00.
  task automatic test_reset_mid_tail();
    bit bits[4];
    bits = '{1, 0, 1, 1};
    en_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d_a = (k < 4) ? bits[k] : 1'b0;
      if (k == 4) en_a = 1'b0;
      tick();
    end
    n_checks++; if ({rdy_a, end_a} !== 2'b00) begin n_fail++; $display("FAIL rst_tail_pos: got %b want 00", {rdy_a, end_a}); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if ({vld_a, st_a, end_a, sym_a} !== 5'b0) begin n_fail++; $display("FAIL rst_async_out: got %b want 00000", {vld_a, st_a, end_a, sym_a}); end
    n_checks++; if (wc_a !== 16'd0) begin n_fail++; $display("FAIL rst_async_word_ct: got %0d want 0", wc_a); end
    n_checks++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready: got %b want 1", rdy_a); end
    tick();
    n_checks++; if ({vld_a, end_a} !== 2'b00) begin n_fail++; $display("FAIL rst_no_end: got %b want 00", {vld_a, end_a}); end
    rst = 1'b1;
    en_a = 1'b1; d_a = 1'b1;
    tick();
    en_a = 1'b0;
    n_checks++; if ({vld_a, st_a, end_a, sym_a} !== 5'b11011) begin n_fail++; $display("FAIL rst_restart: got %b want 11011", {vld_a, st_a, end_a, sym_a}); end
    n_checks++; if (bc_a !== 16'd1) begin n_fail++; $display("FAIL rst_restart_bit_ct: got %0d want 1", bc_a); end
  endtask

  // Three back-to-back random 256-bit frames with no idle symbol between.
  task automatic test_back_to_back();
    bit data[$];
    bit fr[$];
    logic [3:0] e;
    int idx, nsym, gaps;
    exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      fr.delete();
      for (int i = 0; i < 256; i++) begin
        fr.push_back(1'($urandom));
        data.push_back(fr[i]);
      end
      add_frame(fr);
    end
    idx = 0; nsym = 0; gaps = 0;
    for (int cyc = 0; cyc < 2000 && nsym < 774; cyc++) begin
      if (idx < 768 && rdy_b) begin
        en_b = 1'b1; d_b = data[idx]; idx++;
      end else begin
        en_b = (idx < 768); d_b = 1'($urandom);
      end
      tick();
      if (vld_b) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_extra: got symbol %b want none", sym_b);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if ({st_b, end_b, sym_b} !== e) begin n_fail++; $display("FAIL b2b_sym n=%0d: got %b want %b", nsym, {st_b, end_b, sym_b}, e); end
        end
        nsym++;
      end else if (nsym > 0) begin
        gaps++;
      end
    end
    en_b = 1'b0;
    n_checks++; if (nsym !== 774) begin n_fail++; $display("FAIL b2b_count: got %0d want 774", nsym); end
    n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
    n_checks++; if (wc_b !== 16'd3) begin n_fail++; $display("FAIL b2b_word_ct: got %0d want 3", wc_b); end
    n_checks++; if (bc_b !== 16'd0) begin n_fail++; $display("FAIL b2b_bit_ct: got %0d want 0", bc_b); end
  endtask

  // FRAME_LEN=1 with a 2-bit frame counter: 1,2,3,0,1.
  task automatic test_word_wrap();
    logic [1:0] want[5];
    bit fr[$];
    logic [3:0] e;
    int nacc, ends;
    want = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_q.delete();
    nacc = 0; ends = 0;
    for (int cyc = 0; cyc < 100 && ends < 5; cyc++) begin
      if (rdy_c && nacc < 5) begin
        en_c = 1'b1; d_c = 1'($urandom);
        fr.delete(); fr.push_back(d_c);
        add_frame(fr);
        nacc++;
      end else begin
        en_c = !rdy_c; d_c = 1'($urandom);
      end
      tick();
      if (vld_c && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++; if ({st_c, end_c, sym_c} !== e) begin n_fail++; $display("FAIL wrap_sym: got %b want %b", {st_c, end_c, sym_c}, e); end
      end
      if (end_c) begin
        n_checks++; if (wc_c !== want[ends]) begin n_fail++; $display("FAIL wrap_word_ct f=%0d: got %0d want %0d", ends, wc_c, want[ends]); end
        ends++;
      end
    end
    en_c = 1'b0;
    n_checks++; if (ends !== 5) begin n_fail++; $display("FAIL wrap_frames: got %0d want 5", ends); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gap();
    test_flush();
    test_reset_mid_tail();
    test_back_to_back();
    test_word_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
